// File: rtl/gcd_host_pkg.sv
// rtl/gcd_host_pkg.sv - shared state, error codes and timing defaults for the GCD host controller
package gcd_host_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PRST,
      WAIT_X,
      ENT_X,
      WAIT_Y,
      ENT_Y,
      WAIT_HALT,
      DONE
   } state_t;

   typedef enum logic [1:0] {
      ERR_OK         = 2'd0,
      ERR_ZERO       = 2'd1,
      ERR_TIMEOUT    = 2'd2,
      ERR_EARLY_HALT = 2'd3
   } err_t;

   localparam int DEF_W            = 8;
   localparam int DEF_RST_CYCLES   = 1;
   localparam int DEF_PRE_X_CYCLES = 4;
   localparam int DEF_GAP_CYCLES   = 7;
   localparam int DEF_ENTER_CYCLES = 1;
   localparam int DEF_TIMEOUT      = 4096;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Successor within the operand-entry sequence, once the current dwell expires.
   function automatic state_t next_entry_state(input state_t s);
      case (s)
         WAIT_X:  return ENT_X;
         ENT_X:   return WAIT_Y;
         WAIT_Y:  return ENT_Y;
         default: return WAIT_HALT;
      endcase
   endfunction

endpackage

// File: rtl/gcd_host_ctrl_timer.sv
// rtl/gcd_host_ctrl_timer.sv - shared dwell counter with clear and terminal-count compare
module gcd_host_timer #(
   parameter int CW = 8
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          clear,
   input  logic          en,
   input  logic [CW-1:0] limit,
   output logic          tc
);

   logic [CW-1:0] count;

   // Count up while enabled; clear wins so each state dwell starts from zero.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (en)
         count <= count + 1'b1;
   end

   assign tc = (count == limit);

endmodule

// File: rtl/gcd_host_ctrl.sv
// rtl/gcd_host_ctrl.sv - host-side operand entry and result collection for the GCD Processor
module gcd_host_ctrl
   import gcd_host_pkg::*;
#(
   parameter int W            = DEF_W,
   parameter int RST_CYCLES   = DEF_RST_CYCLES,
   parameter int PRE_X_CYCLES = DEF_PRE_X_CYCLES,
   parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
   parameter int ENTER_CYCLES = DEF_ENTER_CYCLES,
   parameter int TIMEOUT      = DEF_TIMEOUT
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [W-1:0] req_x,
   input  logic [W-1:0] req_y,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [W-1:0] rsp_data,
   output logic [1:0]   rsp_err,
   output logic         proc_reset,
   output logic         proc_cheat,
   output logic         proc_enter,
   output logic [W-1:0] proc_min,
   input  logic [W-1:0] proc_mout,
   input  logic         proc_halt
);

   localparam int CW = $clog2(max3(TIMEOUT, PRE_X_CYCLES, GAP_CYCLES) + 1);

   state_t        state;
   err_t          err_q;
   logic [W-1:0]  x_q;
   logic [W-1:0]  y_q;
   logic [W-1:0]  data_q;
   logic          released_q;
   logic [CW-1:0] limit;
   logic          leave;
   logic          tc;
   logic          cnt_en;

   // Per-state dwell limit and the condition under which the state is left.
   // The Y wait is one short because the gap is measured from the last X Enter cycle.
   always_comb begin
      limit = '0;
      leave = 1'b0;
      case (state)
         IDLE:      leave = req_valid;
         PRST:      begin limit = CW'(RST_CYCLES - 1);   leave = tc;             end
         WAIT_X:    begin limit = CW'(PRE_X_CYCLES - 1); leave = tc | proc_halt; end
         ENT_X:     begin limit = CW'(ENTER_CYCLES - 1); leave = tc | proc_halt; end
         WAIT_Y:    begin limit = CW'(GAP_CYCLES - 2);   leave = tc | proc_halt; end
         ENT_Y:     begin limit = CW'(ENTER_CYCLES - 1); leave = tc | proc_halt; end
         WAIT_HALT: begin limit = CW'(TIMEOUT - 1);      leave = tc | proc_halt; end
         DONE:      leave = rsp_ready;
         default:   leave = 1'b0;
      endcase
   end

   assign cnt_en = (state != IDLE) && (state != DONE);

   gcd_host_timer #(.CW(CW)) u_timer (
      .clock (clock),
      .reset (reset),
      .clear (leave),
      .en    (cnt_en),
      .limit (limit),
      .tc    (tc)
   );

   // Run sequencer: accept operands, pulse the Processor through entry, collect the result.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         err_q      <= ERR_OK;
         x_q        <= '0;
         y_q        <= '0;
         data_q     <= '0;
         released_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  x_q <= req_x;
                  y_q <= req_y;
                  if (req_x == '0 || req_y == '0) begin
                     data_q <= '0;
                     err_q  <= ERR_ZERO;
                     state  <= DONE;
                  end else begin
                     released_q <= 1'b0;
                     state      <= PRST;
                  end
               end
            end
            PRST: begin
               if (tc) begin
                  released_q <= 1'b1;
                  state      <= WAIT_X;
               end
            end
            WAIT_X, ENT_X, WAIT_Y, ENT_Y: begin
               if (proc_halt) begin
                  data_q <= '0;
                  err_q  <= ERR_EARLY_HALT;
                  state  <= DONE;
               end else if (tc) begin
                  state <= next_entry_state(state);
               end
            end
            WAIT_HALT: begin
               if (proc_halt) begin
                  data_q <= proc_mout;
                  err_q  <= ERR_OK;
                  state  <= DONE;
               end else if (tc) begin
                  data_q <= '0;
                  err_q  <= ERR_TIMEOUT;
                  state  <= DONE;
               end
            end
            DONE: begin
               if (rsp_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign req_ready  = (state == IDLE);
   assign rsp_valid  = (state == DONE);
   assign rsp_data   = data_q;
   assign rsp_err    = err_q;
   assign proc_reset = released_q;
   assign proc_cheat = 1'b0;
   assign proc_enter = (state == ENT_X) || (state == ENT_Y);
   assign proc_min   = (state == ENT_X) ? x_q :
                       (state == ENT_Y) ? y_q : '0;

endmodule

// File: tb/tb_gcd_host_ctrl.sv
// tb/tb_gcd_host_ctrl.sv - scoreboard bench for gcd_host_ctrl with a behavioural Processor
module tb_gcd_host_ctrl;
   import gcd_host_pkg::*;

   localparam int W  = 8;
   localparam int TO = 64;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic [W-1:0] req_x = '0;
   logic [W-1:0] req_y = '0;
   logic         rsp_valid;
   logic         rsp_ready = 1'b1;
   logic [W-1:0] rsp_data;
   logic [1:0]   rsp_err;
   logic         proc_reset;
   logic         proc_cheat;
   logic         proc_enter;
   logic [W-1:0] proc_min;
   logic [W-1:0] proc_mout = '0;
   logic         proc_halt = 1'b0;

   always #5 clock = ~clock;

   gcd_host_ctrl #(.W(W), .TIMEOUT(TO)) dut (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_x      (req_x),
      .req_y      (req_y),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err),
      .proc_reset (proc_reset),
      .proc_cheat (proc_cheat),
      .proc_enter (proc_enter),
      .proc_min   (proc_min),
      .proc_mout  (proc_mout),
      .proc_halt  (proc_halt)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Processor model: 0 = normal halt after delay, 1 = never halts, 2 = halts during the Y gap
   int           mode = 0;
   int           halt_delay = 3;
   logic [W-1:0] m_x = '0;
   logic [W-1:0] m_y = '0;
   int           m_nent = 0;
   int           m_cnt = 0;
   logic         m_arm = 1'b0;

   function automatic logic [W-1:0] gcd_mod(input logic [W-1:0] a_in, input logic [W-1:0] b_in);
      logic [W-1:0] a, b, t;
      a = a_in;
      b = b_in;
      while (b != 0) begin
         t = a % b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   always @(posedge clock) begin
      if (!proc_reset) begin
         proc_halt <= 1'b0;
         proc_mout <= '0;
         m_nent    <= 0;
         m_arm     <= 1'b0;
         m_cnt     <= 0;
      end else if (proc_enter) begin
         if (m_nent == 0) begin
            m_x <= proc_min;
            if (mode == 2) begin m_arm <= 1'b1; m_cnt <= 2; end
         end else begin
            m_y <= proc_min;
            if (mode == 0) begin m_arm <= 1'b1; m_cnt <= halt_delay; end
         end
         m_nent <= m_nent + 1;
      end else if (m_arm) begin
         if (m_cnt == 0) begin
            m_arm     <= 1'b0;
            proc_halt <= 1'b1;
            proc_mout <= (mode == 0) ? gcd_mod(m_x, m_y) : '0;
         end else begin
            m_cnt <= m_cnt - 1;
         end
      end
   end

   typedef struct packed {
      logic [W-1:0] data;
      logic [1:0]   err;
   } exp_t;

   exp_t sb_q[$];
   exp_t sb_e;

   function automatic exp_t expect_of(input logic [W-1:0] x, input logic [W-1:0] y, input int md);
      exp_t r;
      logic [W-1:0] a, b;
      r.data = '0;
      if (x == 0 || y == 0)  r.err = ERR_ZERO;
      else if (md == 1)      r.err = ERR_TIMEOUT;
      else if (md == 2)      r.err = ERR_EARLY_HALT;
      else begin
         r.err = ERR_OK;
         a = x;
         b = y;
         while (a != b) begin
            if (a > b) a = a - b;
            else       b = b - a;
         end
         r.data = a;
      end
      return r;
   endfunction

   always @(negedge clock) begin
      if (reset && rsp_valid && rsp_ready) begin
         if (sb_q.size() == 0) begin
            check("sb_extra_rsp", 1, 0);
         end else begin
            sb_e = sb_q.pop_front();
            check("rsp_data", rsp_data, sb_e.data);
            check("rsp_err", rsp_err, sb_e.err);
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
      int n;
      n = 0;
      req_x     = x;
      req_y     = y;
      req_valid = 1'b1;
      while (!req_ready && n < 200) begin
         step();
         n++;
      end
      check("req_accept", n < 200, 1);
      sb_q.push_back(expect_of(x, y, mode));
      step();
      req_valid = 1'b0;
   endtask

   task automatic run_to_rsp(output int k_rsp, output int n_ent, output int k_e1, output int k_e2,
                             output int min1, output int min2, output int k_h);
      int k;
      k = 1; k_rsp = -1; n_ent = 0; k_e1 = -1; k_e2 = -1; min1 = -1; min2 = -1; k_h = -1;
      while (k <= 300) begin
         if (proc_enter) begin
            n_ent++;
            if (n_ent == 1) begin k_e1 = k; min1 = int'(proc_min); end
            if (n_ent == 2) begin k_e2 = k; min2 = int'(proc_min); end
         end
         if (proc_halt && k_h < 0 && n_ent >= 1) k_h = k;
         if (rsp_valid) begin
            k_rsp = k;
            break;
         end
         step();
         k++;
      end
      check("rsp_seen", k_rsp > 0, 1);
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_req_ready"},  req_ready,  1);
      check({pfx, "_rsp_valid"},  rsp_valid,  0);
      check({pfx, "_rsp_data"},   rsp_data,   0);
      check({pfx, "_rsp_err"},    rsp_err,    0);
      check({pfx, "_proc_reset"}, proc_reset, 0);
      check({pfx, "_proc_enter"}, proc_enter, 0);
      check({pfx, "_proc_min"},   proc_min,   0);
      check({pfx, "_proc_cheat"}, proc_cheat, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int k_rsp, n_ent, k_e1, k_e2, min1, min2, k_h;
      logic saw;

      #2 reset = 1'b0;
      #1 check_reset_outputs("rst");
      step();
      step();
      reset = 1'b1;
      step();

      // nominal run with entry timing
      mode = 0; halt_delay = 3;
      send(8'd12, 8'd18);
      run_to_rsp(k_rsp, n_ent, k_e1, k_e2, min1, min2, k_h);
      check("x_enter_cycle", k_e1, 6);
      check("y_enter_cycle", k_e2, 13);
      check("x_enter_min", min1, 12);
      check("y_enter_min", min2, 18);
      check("enter_count", n_ent, 2);
      check("halt_to_valid", k_rsp, k_h + 1);
      step();

      // zero operand: immediate response, Processor untouched
      send(8'd0, 8'd5);
      run_to_rsp(k_rsp, n_ent, k_e1, k_e2, min1, min2, k_h);
      check("zero_rsp_cycle", k_rsp, 1);
      check("zero_enter_count", n_ent, 0);
      step();

      // timeout: Processor never halts
      mode = 1;
      send(8'd40, 8'd30);
      run_to_rsp(k_rsp, n_ent, k_e1, k_e2, min1, min2, k_h);
      check("timeout_y_cycle", k_e2, 13);
      check("timeout_cycle", k_rsp, 13 + 1 + TO);
      step();

      // back-pressure: response held, second request ignored
      mode = 0; halt_delay = 5;
      rsp_ready = 1'b0;
      send(8'd91, 8'd56);
      run_to_rsp(k_rsp, n_ent, k_e1, k_e2, min1, min2, k_h);
      req_x = 8'd3; req_y = 8'd3; req_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         check("hold_rsp_valid", rsp_valid, 1);
         check("hold_rsp_data", rsp_data, 7);
         check("hold_req_ready", req_ready, 0);
         step();
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      step();
      check("post_hs_req_ready", req_ready, 1);
      check("post_hs_rsp_valid", rsp_valid, 0);
      step();
      check("ignored_req_idle", req_ready, 1);

      // early halt during the Y gap
      mode = 2;
      send(8'd9, 8'd6);
      run_to_rsp(k_rsp, n_ent, k_e1, k_e2, min1, min2, k_h);
      check("early_enter_count", n_ent, 1);
      step();

      // random operand pairs
      mode = 0;
      for (int i = 0; i < 100; i++) begin
         halt_delay = int'($urandom_range(0, 40));
         send(8'($urandom_range(1, 127)), 8'($urandom_range(1, 127)));
         run_to_rsp(k_rsp, n_ent, k_e1, k_e2, min1, min2, k_h);
         step();
      end

      // reset mid-run during the Y gap drops the request
      halt_delay = 3;
      send(8'd10, 8'd4);
      for (int i = 0; i < 7; i++) step();
      reset = 1'b0;
      #1 check_reset_outputs("midrst");
      void'(sb_q.pop_back());
      step();
      step();
      reset = 1'b1;
      saw = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (rsp_valid) saw = 1'b1;
         step();
      end
      check("midrst_no_rsp", saw, 0);
      send(8'd21, 8'd14);
      run_to_rsp(k_rsp, n_ent, k_e1, k_e2, min1, min2, k_h);
      check("midrst_next_y_cycle", k_e2, 13);

      repeat (3) step();
      check("sb_empty", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
